// File: rtl/perf_arb_pkg.sv
// Shared types for the perf-counter read arbiter.
// State encoding and AXI response codes.
package perf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD_AR = 2'd1,
    FWD_R  = 2'd2,
    ERR_R  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/perf_counter_read_arbiter_rr_arb2.sv
// Two-input round-robin picker, purely combinational.
// The last_grant history register lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       winner
);

  // Lone requester wins; on contention the one not served last wins.
  always_comb begin
    winner = ~last_grant;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_grant;
    endcase
    gnt = 2'b00;
    if (enable) begin
      gnt[winner] = req[winner];
    end
  end

endmodule

// File: rtl/perf_counter_read_arbiter.sv
// Shares the perf-counter AXI-lite read port between CPU and sampler.
// One transaction in flight; out-of-window reads answered with DECERR.
module perf_counter_read_arbiter
  import perf_arb_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WIN_BITS  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp
);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [1:0]        gnt;
  logic              winner;
  logic              arb_en;
  logic [ADDR_W-1:0] acc_addr;
  logic              in_win;
  logic              sel_rready;
  logic              rv;
  logic [DATA_W-1:0] rd;
  logic [1:0]        rr;

  assign arb_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .req        ({s1_arvalid, s0_arvalid}),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .gnt        (gnt),
    .winner     (winner)
  );

  assign s0_arready = gnt[0];
  assign s1_arready = gnt[1];

  assign acc_addr = winner ? s1_araddr : s0_araddr;
  assign in_win =
    acc_addr[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS];

  assign sel_rready = grant_q ? s1_rready : s0_rready;

  assign m_araddr = addr_q;

  // Next-state: accept in IDLE, then forward or answer locally.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          addr_d       = acc_addr;
          grant_d      = winner;
          last_grant_d = winner;
          state_d      = in_win ? FWD_AR : ERR_R;
        end
      end
      FWD_AR: begin
        if (m_arready) state_d = FWD_R;
      end
      FWD_R: begin
        if (m_rvalid && m_rready) state_d = IDLE;
      end
      ERR_R: begin
        if (sel_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: AR towards counters, R steered to the granted side.
  always_comb begin
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    rv        = 1'b0;
    rd        = '0;
    rr        = RESP_OKAY;
    unique case (state_q)
      FWD_AR: m_arvalid = 1'b1;
      FWD_R: begin
        rv       = m_rvalid;
        rd       = m_rdata;
        rr       = m_rresp;
        m_rready = sel_rready;
      end
      ERR_R: begin
        rv = 1'b1;
        rr = RESP_DECERR;
      end
      default: ;
    endcase
    s0_rvalid = rv & ~grant_q;
    s1_rvalid = rv & grant_q;
    s0_rdata  = grant_q ? '0 : rd;
    s1_rdata  = grant_q ? rd : '0;
    s0_rresp  = grant_q ? RESP_OKAY : rr;
    s1_rresp  = grant_q ? rr : RESP_OKAY;
  end

  // State and transaction registers; requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
    end
  end

endmodule
